iob_iob2wishbone: RTL and testbench
===================================

IOB_IOB2WISHBONE -- requirements
Module: iob_iob2wishbone

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits; DATA_W/8 byte lanes.
REQ-003 SHALL have parameter TIMEOUT_W, default 8, width of the watchdog counter.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port arst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port valid_i  input  1  IOb request strobe.
REQ-007 SHALL have port address_i  input  ADDR_W  IOb request address.
REQ-008 SHALL have port wdata_i  input  DATA_W  IOb write data.
REQ-009 SHALL have port wstrb_i  input  DATA_W/8  IOb write strobes; all-zero means read.
REQ-010 SHALL have port rdata_o  output  DATA_W  IOb read data.
REQ-011 SHALL have port ready_o  output  1  IOb completion pulse.
REQ-012 SHALL have port error_o  output  1  completion-with-error flag, valid with ready_o.
REQ-013 SHALL have ports wb_addr_o (ADDR_W), wb_data_o (DATA_W), wb_select_o (DATA_W/8), wb_we_o, wb_cyc_o, wb_stb_o (1 each), all outputs: Wishbone master request.
REQ-014 SHALL have ports wb_data_i (DATA_W), wb_ack_i, wb_err_i (1 each), all inputs: Wishbone master response.

Function
REQ-015 SHALL implement FSM IDLE and BUSY; reset state IDLE.
REQ-016 In IDLE, valid_i=1 SHALL capture address_i, wdata_i, wstrb_i into registers and move to BUSY; valid_i while BUSY SHALL be ignored.
REQ-017 In BUSY, wb_cyc_o and wb_stb_o SHALL be 1, driven from registers: wb_addr_o=captured address, wb_data_o=captured wdata, wb_we_o=|captured wstrb, wb_select_o=captured wstrb on write, all-ones on read.
REQ-018 Wishbone outputs SHALL not change during BUSY; in IDLE wb_cyc_o=wb_stb_o=0.
REQ-019 Latency: valid_i at edge N SHALL give wb_cyc_o=wb_stb_o=1 from cycle N+1; zero-wait-state ack gives ready_o at N+2.
REQ-020 wb_ack_i or wb_err_i sampled in BUSY SHALL return to IDLE, deassert wb_cyc_o/wb_stb_o next cycle and pulse ready_o for exactly one cycle.
REQ-021 On ack of a read, rdata_o SHALL load wb_data_i and hold until the next read completes; writes SHALL not change rdata_o.
REQ-022 error_o SHALL equal 1 only during a ready_o pulse caused by error or timeout.
REQ-023 Simultaneous wb_ack_i and wb_err_i SHALL be treated as error; rdata_o unchanged.
REQ-024 valid_i in the ready_o cycle SHALL be accepted (back-to-back: one idle Wishbone cycle between transactions).
REQ-025 wb_ack_i/wb_err_i in IDLE SHALL be ignored.

Reset
REQ-026 arst_n_i=0 SHALL immediately force IDLE, rdata_o=0, ready_o=0, error_o=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_addr_o=0, wb_data_o=0, wb_select_o=0, counter=0.
REQ-027 Reset during BUSY SHALL abandon the cycle with no ready_o pulse.

Configuration
REQ-028 With IOB2WB_TIMEOUT_EN defined, a counter SHALL clear on BUSY entry, increment each BUSY cycle without ack/err; reaching 2^TIMEOUT_W-1 SHALL abort: IDLE, ready_o=1, error_o=1, rdata_o unchanged.
REQ-029 Without IOB2WB_TIMEOUT_EN, no counter SHALL exist and BUSY SHALL persist until wb_ack_i or wb_err_i.

Verification
REQ-030 Read: valid_i, address_i=0x100, wstrb_i=0; ack at cycle 2 with wb_data_i=0xDEADBEEF -> wb_we_o=0, wb_select_o=0xF, ready_o one pulse, rdata_o=0xDEADBEEF, error_o=0.
REQ-031 Write: address_i=0x20, wdata_i=0x12345678, wstrb_i=0x3; ack after 3 wait states -> wb_we_o=1, wb_select_o=0x3, stable 4 cycles, ready_o one pulse, rdata_o unchanged.
REQ-032 Error: read with wb_ack_i=wb_err_i=1 same cycle -> ready_o=1, error_o=1, rdata_o keeps prior 0xDEADBEEF.
REQ-033 Timeout (macro on, TIMEOUT_W=4): no response -> ready_o=error_o=1 after 15 BUSY cycles; macro off -> wb_cyc_o held 100+ cycles.
REQ-034 Back-to-back: valid_i held high, zero-wait ack -> ready_o every 2 cycles, wb_cyc_o low one cycle between.
REQ-035 Reset mid-BUSY: arst_n_i=0 -> wb_cyc_o=0 same cycle, no ready_o after release.

Source files
------------

// File: rtl/iob_iob2wishbone.sv
`default_nettype none
// ============================================================================
// Module      : iob_iob2wishbone
// Description : IOb slave to Wishbone classic master bridge, one outstanding
//               transaction. Define IOB2WB_TIMEOUT_EN to add a watchdog abort.
// Revision    : 1.0 - initial release
// ============================================================================
module iob_iob2wishbone #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                valid_i,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                ready_o,
    output logic                error_o,
    output logic [ADDR_W-1:0]   wb_addr_o,
    output logic [DATA_W-1:0]   wb_data_o,
    output logic [DATA_W/8-1:0] wb_select_o,
    output logic                wb_we_o,
    output logic                wb_cyc_o,
    output logic                wb_stb_o,
    input  logic [DATA_W-1:0]   wb_data_i,
    input  logic                wb_ack_i,
    input  logic                wb_err_i
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   select_q;
    logic                we_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                ready_q;
    logic                error_q;
    logic                accept;
    logic                respond;
    logic                timeout;

    assign accept  = (state == IDLE) && valid_i;
    assign respond = (state == BUSY) && (wb_ack_i || wb_err_i);

`ifdef IOB2WB_TIMEOUT_EN
    // Counter holds the number of completed silent BUSY cycles, so the abort
    // fires on the cycle in which it would reach 2^TIMEOUT_W-1.
    localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);

    logic [TIMEOUT_W-1:0] counter;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            counter <= '0;
        end else if (accept) begin
            counter <= '0;
        end else if ((state == BUSY) && !respond) begin
            counter <= counter + 1'b1;
        end
    end

    assign timeout = (state == BUSY) && !respond && (counter == LAST_COUNT);
`else
    // No watchdog: the cycle only ends on a Wishbone response.
    assign timeout = 1'b0 & (TIMEOUT_W > 0);
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (respond || timeout) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request is frozen at acceptance so the bus stays stable for the whole cycle.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            select_q <= '0;
            we_q     <= 1'b0;
        end else if (accept) begin
            addr_q   <= address_i;
            wdata_q  <= wdata_i;
            we_q     <= |wstrb_i;
            select_q <= (|wstrb_i) ? wstrb_i : {STRB_W{1'b1}};
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            ready_q <= respond || timeout;
            error_q <= (respond && wb_err_i) || timeout;
            if (respond && wb_ack_i && !wb_err_i && !we_q) begin
                rdata_q <= wb_data_i;
            end
        end
    end

    assign rdata_o     = rdata_q;
    assign ready_o     = ready_q;
    assign error_o     = error_q;
    assign wb_addr_o   = addr_q;
    assign wb_data_o   = wdata_q;
    assign wb_select_o = select_q;
    assign wb_we_o     = we_q;
    assign wb_cyc_o    = (state == BUSY);
    assign wb_stb_o    = (state == BUSY);

endmodule
`default_nettype wire

// File: tb/tb_iob_iob2wishbone.sv
`default_nettype none
// ============================================================================
// Module      : tb_iob_iob2wishbone
// Description : Table-driven bench with a completion scoreboard for the bridge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iob_iob2wishbone;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        valid = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata_o;
    logic        ready_o;
    logic        error_o;
    logic [31:0] wb_addr_o;
    logic [31:0] wb_data_o;
    logic [3:0]  wb_select_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_din = '0;
    logic        wb_ack = 1'b0;
    logic        wb_err = 1'b0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          waits;
        logic        ack;
        logic        err;
        logic [31:0] din;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    vec_t        vecs[7];
    resp_t       sb[$];
    logic [31:0] exp_rdata;

    iob_iob2wishbone #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .TIMEOUT_W(4)
    ) dut (
        .clk_i      (clk),
        .arst_n_i   (arst_n),
        .valid_i    (valid),
        .address_i  (address),
        .wdata_i    (wdata),
        .wstrb_i    (wstrb),
        .rdata_o    (rdata_o),
        .ready_o    (ready_o),
        .error_o    (error_o),
        .wb_addr_o  (wb_addr_o),
        .wb_data_o  (wb_data_o),
        .wb_select_o(wb_select_o),
        .wb_we_o    (wb_we_o),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_data_i  (wb_din),
        .wb_ack_i   (wb_ack),
        .wb_err_i   (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every completion pulse must match the oldest outstanding expectation.
    resp_t mon_e;
    always @(negedge clk) begin
        if (arst_n) begin
            if (ready_o) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ready: got ready_o=1 expected 0");
                end else begin
                    mon_e = sb.pop_front();
                    check("resp_error", {63'd0, error_o}, {63'd0, mon_e.err});
                    check("resp_rdata", {32'd0, rdata_o}, {32'd0, mon_e.rdata});
                end
            end else begin
                check("error_outside_ready", {63'd0, error_o}, 64'd0);
            end
        end
    end

    task automatic check_busy(input vec_t v);
        check("busy_cyc", {63'd0, wb_cyc_o}, 64'd1);
        check("busy_stb", {63'd0, wb_stb_o}, 64'd1);
        check("busy_addr", {32'd0, wb_addr_o}, {32'd0, v.addr});
        check("busy_data", {32'd0, wb_data_o}, {32'd0, v.wdata});
        check("busy_we", {63'd0, wb_we_o}, {63'd0, v.exp_we});
        check("busy_sel", {60'd0, wb_select_o}, {60'd0, v.exp_sel});
    endtask

    task automatic run_vec(input vec_t v);
        valid   = 1'b1;
        address = v.addr;
        wdata   = v.wdata;
        wstrb   = v.wstrb;
        sb.push_back('{v.exp_rdata, v.exp_err});
        @(posedge clk); #1;
        // A fresh request while BUSY must not disturb the bus.
        address = ~v.addr;
        wdata   = ~v.wdata;
        wstrb   = ~v.wstrb;
        for (int i = 0; i < v.waits; i++) begin
            check_busy(v);
            @(posedge clk); #1;
        end
        check_busy(v);
        valid  = 1'b0;
        wb_ack = v.ack;
        wb_err = v.err;
        wb_din = v.din;
        @(posedge clk); #1;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        check("done_ready", {63'd0, ready_o}, 64'd1);
        check("done_cyc", {63'd0, wb_cyc_o}, 64'd0);
        check("done_stb", {63'd0, wb_stb_o}, 64'd0);
        @(posedge clk); #1;
        check("ready_single_pulse", {63'd0, ready_o}, 64'd0);
    endtask

    initial begin
        vec_t tv;
        //           addr          wdata         strb  w  ack   err   din           we    sel   err   rdata
        vecs[0] = '{32'h0000_0100, 32'h0,        4'h0, 0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 4'hF, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{32'h0000_0020, 32'h12345678, 4'h3, 3, 1'b1, 1'b0, 32'hAAAA5555, 1'b1, 4'h3, 1'b0, 32'hDEADBEEF};
        vecs[2] = '{32'h0000_0200, 32'h0,        4'h0, 0, 1'b1, 1'b1, 32'h11111111, 1'b0, 4'hF, 1'b1, 32'hDEADBEEF};
        vecs[3] = '{32'h0000_0300, 32'h0,        4'h0, 1, 1'b0, 1'b1, 32'h22222222, 1'b0, 4'hF, 1'b1, 32'hDEADBEEF};
        vecs[4] = '{32'h0000_0400, 32'h0,        4'h0, 2, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 4'hF, 1'b0, 32'hCAFEF00D};
        vecs[5] = '{32'h0000_0404, 32'h0BADC0DE, 4'hF, 0, 1'b1, 1'b0, 32'h33333333, 1'b1, 4'hF, 1'b0, 32'hCAFEF00D};
        vecs[6] = '{32'h0000_0408, 32'h55AA55AA, 4'h8, 1, 1'b0, 1'b1, 32'h44444444, 1'b1, 4'h8, 1'b1, 32'hCAFEF00D};

        // Reset state
        #12;
        check("rst_rdata", {32'd0, rdata_o}, 64'd0);
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        check("rst_error", {63'd0, error_o}, 64'd0);
        check("rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
        check("rst_stb", {63'd0, wb_stb_o}, 64'd0);
        check("rst_we", {63'd0, wb_we_o}, 64'd0);
        check("rst_addr", {32'd0, wb_addr_o}, 64'd0);
        check("rst_data", {32'd0, wb_data_o}, 64'd0);
        check("rst_sel", {60'd0, wb_select_o}, 64'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);
        exp_rdata = 32'hCAFEF00D;

        // Responses while IDLE are ignored
        wb_ack = 1'b1;
        wb_err = 1'b1;
        wb_din = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("idle_ack_ready", {63'd0, ready_o}, 64'd0);
            check("idle_ack_cyc", {63'd0, wb_cyc_o}, 64'd0);
            check("idle_ack_rdata", {32'd0, rdata_o}, {32'd0, exp_rdata});
        end
        wb_ack = 1'b0;
        wb_err = 1'b0;
        @(posedge clk); #1;

        // Back-to-back reads with valid held high and zero-wait acks
        valid   = 1'b1;
        address = 32'h0000_0500;
        wstrb   = 4'h0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("b2b_cyc_high", {63'd0, wb_cyc_o}, 64'd1);
            check("b2b_ready_low", {63'd0, ready_o}, 64'd0);
            wb_ack    = 1'b1;
            wb_din    = 32'h1000_0000 + 32'(i);
            exp_rdata = wb_din;
            sb.push_back('{exp_rdata, 1'b0});
            @(posedge clk); #1;
            wb_ack = 1'b0;
            check("b2b_cyc_low", {63'd0, wb_cyc_o}, 64'd0);
            check("b2b_ready", {63'd0, ready_o}, 64'd1);
            if (i == 3) valid = 1'b0;
        end
        @(posedge clk); #1;
        check("b2b_stopped", {63'd0, wb_cyc_o}, 64'd0);

`ifdef IOB2WB_TIMEOUT_EN
        // Silent slave: abort after 15 BUSY cycles with error
        valid   = 1'b1;
        address = 32'h0000_0700;
        wstrb   = 4'h0;
        sb.push_back('{exp_rdata, 1'b1});
        @(posedge clk); #1;
        valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("timeout_busy_cyc", {63'd0, wb_cyc_o}, 64'd1);
            check("timeout_busy_ready", {63'd0, ready_o}, 64'd0);
            @(posedge clk); #1;
        end
        check("timeout_cyc_low", {63'd0, wb_cyc_o}, 64'd0);
        check("timeout_ready", {63'd0, ready_o}, 64'd1);
        check("timeout_error", {63'd0, error_o}, 64'd1);
        @(posedge clk); #1;
`else
        // Silent slave: cycle held indefinitely, then completes normally
        tv = '{32'h0000_0700, 32'h0, 4'h0, 110, 1'b1, 1'b0, 32'h7777_0000,
               1'b0, 4'hF, 1'b0, 32'h7777_0000};
        run_vec(tv);
        exp_rdata = 32'h7777_0000;
`endif

        // Reset in the middle of a write
        valid   = 1'b1;
        address = 32'h0000_0600;
        wdata   = 32'h6666_6666;
        wstrb   = 4'hF;
        @(posedge clk); #1;
        valid = 1'b0;
        check("pre_rst_cyc", {63'd0, wb_cyc_o}, 64'd1);
        #2;
        arst_n = 1'b0;
        #1;
        check("mid_rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
        check("mid_rst_stb", {63'd0, wb_stb_o}, 64'd0);
        check("mid_rst_we", {63'd0, wb_we_o}, 64'd0);
        check("mid_rst_addr", {32'd0, wb_addr_o}, 64'd0);
        check("mid_rst_data", {32'd0, wb_data_o}, 64'd0);
        check("mid_rst_sel", {60'd0, wb_select_o}, 64'd0);
        check("mid_rst_rdata", {32'd0, rdata_o}, 64'd0);
        check("mid_rst_ready", {63'd0, ready_o}, 64'd0);
        @(posedge clk); #1;
        arst_n = 1'b1;
        exp_rdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("post_rst_ready", {63'd0, ready_o}, 64'd0);
            check("post_rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
        end

        // Bridge usable again after reset
        tv = '{32'h0000_0800, 32'h0, 4'h0, 1, 1'b1, 1'b0, 32'h0F0F_0F0F,
               1'b0, 4'hF, 1'b0, 32'h0F0F_0F0F};
        run_vec(tv);

        @(posedge clk); #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
